uart_prog_loader: RTL and testbench

- UART program loader upstream of the minisys CPU top.
- Receives a length-prefixed instruction image over an 8N1 serial line and assembles it into 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the CPU in reset/stall (cpu_hold) for the whole transfer and releases it when the image is complete.

---
 rtl/uart_prog_loader.sv | 197 +++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// UART program loader: receives a length-prefixed image over 8N1 serial,
// packs it big-endian into 32-bit words and writes them to instruction memory,
// holding the CPU off for the duration of the transfer.
//
// Internal handshake: byte_valid is a 1-cycle pulse from the receiver, and
// rx_byte is stable in that cycle. There is no backpressure, so the loader
// consumes the byte in that cycle or drops it.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 100,
  parameter int ADDR_WIDTH   = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  start,
  output logic                  prog_we,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [31:0]           prog_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE} ld_state_t;

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             frame_err;

  ld_state_t        state;
  logic [15:0]      len;
  logic [15:0]      word_idx;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;
  logic             finish_pending;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // 8N1 receiver: mid-bit sampling, glitch rejection on the start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == FULL_M1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Loader: length header, word assembly, memory writes and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      len            <= '0;
      word_idx       <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      finish_pending <= 1'b0;
      prog_we        <= 1'b0;
      prog_addr      <= '0;
      prog_data      <= '0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      prog_we <= 1'b0;
      if (frame_err) err <= 1'b1;
      case (state)
        IDLE, DONE: begin
          // start takes priority; a byte landing here is simply dropped
          if (start) begin
            state          <= LEN_HI;
            cpu_hold       <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            word_idx       <= '0;
            byte_idx       <= '0;
            finish_pending <= 1'b0;
          end
        end
        LEN_HI: begin
          if (byte_valid) begin
            len[15:8] <= rx_byte;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (byte_valid) begin
            len[7:0] <= rx_byte;
            if ({len[15:8], rx_byte} == 16'd0) begin
              state    <= DONE;
              cpu_hold <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (finish_pending) begin
            // completion lands the cycle after the final write strobe
            finish_pending <= 1'b0;
            state          <= DONE;
            cpu_hold       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
          end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              prog_we   <= 1'b1;
              prog_data <= {word_buf, rx_byte};
              prog_addr <= ADDR_WIDTH'(word_idx);
              word_idx  <= word_idx + 16'd1;
              // any index beyond the address space means the address wrapped
              if ((32'(word_idx) >> ADDR_WIDTH) != 32'd0) err <= 1'b1;
              if (word_idx == len - 16'd1) finish_pending <= 1'b1;
            end else begin
              word_buf <= {word_buf[15:0], rx_byte};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader. An image-level model predicts the
// write stream and status flags; one compare process checks every cycle.
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 2;
  // Cycles from the line's falling edge (start bit) to the visible effect of
  // that byte: 2 sync flops + edge detect, half a bit, 9 more bits to the stop
  // sample, and one registered stage in the loader.
  localparam int LAT = 4 + CPB / 2 + 9 * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          uart_rx = 1'b1;
  logic          start = 1'b0;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic          cpu_hold, busy, done, err;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct { int at; logic [7:0] b; } ev_t;
  ev_t            byte_q[$];
  int             ferr_q[$];
  logic [AW+31:0] exp_q[$];
  int             exp_cyc_q[$];
  logic [AW+31:0] wr_log[$];
  logic [7:0]     img[$];
  logic [7:0]     tx_q[$];
  int             phase = 0;      // 0 idle, 1 loading, 2 done
  int             n_words = 0;
  int             done_at = -1;
  int             start_at = -1;
  int             rst_at = -1;
  logic           m_hold = 0, m_busy = 0, m_done = 0, m_err = 0;
  logic [AW-1:0]  last_addr = '0;
  logic [31:0]    last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic finish_image();
    phase  = 2;
    m_done = 1;
    m_hold = 0;
    m_busy = 0;
  endtask

  // A correctly framed byte becomes visible to the loader now.
  task automatic model_byte(input logic [7:0] b);
    int k;
    logic [AW-1:0] a;
    logic [31:0] d;
    if (phase != 1) return;
    img.push_back(b);
    if (img.size() == 2) begin
      n_words = img[0] * 256 + img[1];
      if (n_words == 0) finish_image();
    end else if (img.size() > 2 && (img.size() - 2) % 4 == 0) begin
      k = (img.size() - 2) / 4 - 1;
      a = AW'(k % (1 << AW));
      d = {img[2 + 4*k], img[3 + 4*k], img[4 + 4*k], img[5 + 4*k]};
      exp_q.push_back({a, d});
      exp_cyc_q.push_back(cyc);
      if (k >= (1 << AW)) m_err = 1;
      if (k == n_words - 1) done_at = cyc + 1;
    end
  endtask

  task automatic model_tick();
    ev_t e;
    if (rst_at == cyc) begin
      phase = 0; img.delete(); byte_q.delete(); ferr_q.delete();
      exp_q.delete(); exp_cyc_q.delete(); done_at = -1;
      m_hold = 0; m_busy = 0; m_done = 0; m_err = 0;
      last_addr = '0; last_data = '0;
    end
    if (start_at == cyc && phase != 1) begin
      phase = 1; img.delete(); done_at = -1;
      m_hold = 1; m_busy = 1; m_done = 0; m_err = 0;
    end
    while (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
      void'(ferr_q.pop_front());
      m_err = 1;
    end
    while (byte_q.size() > 0 && byte_q[0].at == cyc) begin
      e = byte_q.pop_front();
      model_byte(e.b);
    end
    if (done_at == cyc) finish_image();
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [AW+31:0] w;
    model_tick();
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      void'(exp_cyc_q.pop_front());
      void'(exp_q.pop_front());
      check("missed_write", 32'd0, 32'd1);
    end
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      void'(exp_cyc_q.pop_front());
      w = exp_q.pop_front();
      last_addr = w[AW+31:32];
      last_data = w[31:0];
      check("prog_we", 32'(prog_we), 32'd1);
    end else begin
      check("prog_we", 32'(prog_we), 32'd0);
    end
    check("prog_addr", 32'(prog_addr), 32'(last_addr));
    check("prog_data", prog_data, last_data);
    check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    if (prog_we === 1'b1) wr_log.push_back({prog_addr, prog_data});
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    ev_t e;
    @(negedge clk);
    if (stop_bit) begin
      e.at = cyc + LAT; e.b = b;
      byte_q.push_back(e);
    end else begin
      ferr_q.push_back(cyc + LAT);
    end
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_all();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_at = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    rst_at = cyc + 1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_log(input string name, input int idx, input logic [AW-1:0] a, input logic [31:0] d);
    logic [AW+31:0] w;
    if (idx >= wr_log.size()) begin
      check({name, "_present"}, 32'(wr_log.size()), 32'(idx + 1));
    end else begin
      w = wr_log[idx];
      check({name, "_addr"}, 32'(w[AW+31:32]), 32'(a));
      check({name, "_data"}, w[31:0], d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    idle(3);
    check("rst_we", 32'(prog_we), 32'd0);
    check("rst_addr", 32'(prog_addr), 32'd0);
    check("rst_data", prog_data, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b1;
    idle(4);

    // glitch on an idle line, then bytes before any start
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle(20);
    tx_q = '{8'h00, 8'h01};
    send_all();
    idle(6);
    check("pre_start_hold", 32'(cpu_hold), 32'd0);
    check("pre_start_writes", 32'(wr_log.size()), 32'd0);

    // basic two-word load
    pulse_start();
    tx_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_all();
    idle(6);
    check("basic_count", 32'(wr_log.size()), 32'd2);
    check_log("basic_w0", 0, 2'd0, 32'h12345678);
    check_log("basic_w1", 1, 2'd1, 32'h9ABCDEF0);
    check("basic_status", {29'd0, done, cpu_hold, err}, 32'b100);

    // zero-length image
    base = wr_log.size();
    pulse_start();
    tx_q = '{8'h00, 8'h00};
    send_all();
    idle(6);
    check("zero_writes", 32'(wr_log.size()), 32'(base));
    check("zero_done", 32'(done), 32'd1);

    // framing error on the third data byte, then the byte again
    base = wr_log.size();
    pulse_start();
    tx_q = '{8'h00, 8'h01, 8'h12, 8'h34};
    send_all();
    send_byte(8'h56, 1'b0);
    tx_q = '{8'h56, 8'h78};
    send_all();
    idle(6);
    check_log("frame_w0", base, 2'd0, 32'h12345678);
    check("frame_err_after_done", {30'd0, done, err}, 32'b11);

    // reset mid-word, then a fresh image from address 0
    base = wr_log.size();
    pulse_start();
    tx_q = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_all();
    idle(4);
    pulse_reset();
    idle(2);
    check("midrst_writes", 32'(wr_log.size()), 32'(base));
    check("midrst_outputs", {prog_we, cpu_hold, busy, done, err, 27'd0} | 32'(prog_addr) | prog_data, 32'd0);
    pulse_start();
    tx_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    send_all();
    idle(6);
    check_log("midrst_reload", base, 2'd0, 32'hCAFEBABE);

    // start while busy is ignored
    base = wr_log.size();
    pulse_start();
    send_byte(8'h00, 1'b1);
    idle(3);
    pulse_start();
    tx_q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A, 8'hFF, 8'h00};
    send_all();
    idle(6);
    check("busy_start_count", 32'(wr_log.size() - base), 32'd2);
    check_log("busy_start_w1", base + 1, 2'd1, 32'hA55AFF00);

    // address wrap: five words into a four-word space
    base = wr_log.size();
    pulse_start();
    tx_q = '{8'h00, 8'h05};
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(i + 1));
    send_all();
    idle(6);
    check("wrap_count", 32'(wr_log.size() - base), 32'd5);
    check_log("wrap_w4", base + 4, 2'd0, 32'h11121314);
    check("wrap_err_done", {30'd0, done, err}, 32'b11);

    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
